input_conditioner: RTL and testbench

Multi-channel input conditioner for push-buttons, switches and other slow board-level inputs feeding the MCU's `reset`, `halt` and `gpio_input` pins. Each channel goes through a configurable-depth synchroniser and a counter-based debouncer. Each channel also produces a one-cycle rising-edge pulse and a one-cycle falling-edge pulse. The block replaces the single-flop "debounce" register in board top levels and sits between the board pins and `rvsteel_mcu`.

---
 rtl/input_conditioner.sv | 80 ++++++++
 tb/tb_input_conditioner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per-channel synchroniser, counter
// debouncer and registered rise/fall pulses for slow board-level pins.
module input_conditioner #(
    parameter int                  CHANNELS        = 2,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 120000,
    parameter logic [CHANNELS-1:0] RESET_VALUE     = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain [CHANNELS];
    logic [CW-1:0]          count      [CHANNELS];
    logic [CW-1:0]          count_next [CHANNELS];
    logic [CHANNELS-1:0]    sync;
    logic [CHANNELS-1:0]    debounced_next;
    logic [CHANNELS-1:0]    rise_next;
    logic [CHANNELS-1:0]    fall_next;

    // Bit 0 of each chain is the only flop that may go metastable.
    always_ff @(posedge clock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (reset)
                sync_chain[c] <= {SYNC_STAGES{RESET_VALUE[c]}};
            else
                sync_chain[c] <= {sync_chain[c][SYNC_STAGES-2:0], raw_in[c]};
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++)
            sync[c] = sync_chain[c][SYNC_STAGES-1];
    end

    always_comb begin
        debounced_next = debounced;
        rise_next      = '0;
        fall_next      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            count_next[c] = '0;
            if (sync[c] != debounced[c]) begin
                if (count[c] == LAST) begin
                    debounced_next[c] = sync[c];
                    rise_next[c]      = sync[c];
                    fall_next[c]      = ~sync[c];
                end else begin
                    count_next[c] = count[c] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            debounced  <= RESET_VALUE;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
            for (int c = 0; c < CHANNELS; c++)
                count[c] <= '0;
        end else begin
            debounced  <= debounced_next;
            rise       <= rise_next;
            fall       <= fall_next;
            any_change <= |(rise_next | fall_next);
            for (int c = 0; c < CHANNELS; c++)
                count[c] <= count_next[c];
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a sample-history reference
// model queues expected outputs per edge; directed latency checks on top.
module tb_input_conditioner;

    localparam int          CH = 2;
    localparam int          SS = 2;
    localparam int          DC = 4;
    localparam logic [1:0]  RV = 2'b10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  raw_in = 2'b01;
    logic [1:0]  debounced;
    logic [1:0]  rise;
    logic [1:0]  fall;
    logic        any_change;

    int total = 0;
    int bad   = 0;

    input_conditioner #(
        .CHANNELS(CH),
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DC),
        .RESET_VALUE(RV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .raw_in(raw_in),
        .debounced(debounced),
        .rise(rise),
        .fall(fall),
        .any_change(any_change)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a level is accepted once the DC samples seen by the debouncer
    // (raw delayed by SS edges) all differ from the current accepted level.
    logic [1:0] hist [SS+DC];
    logic [1:0] m_deb;
    logic [6:0] sb_q [$];
    bit         started = 0;

    always @(posedge clock) begin
        logic [6:0] e;
        logic [1:0] r;
        logic [1:0] f;
        bit         ok;
        for (int j = SS + DC - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = raw_in;
        r = 2'b00;
        f = 2'b00;
        if (reset) begin
            m_deb = RV;
            for (int j = 0; j < SS + DC; j++) hist[j] = RV;
            started = 1;
        end else if (started) begin
            for (int c = 0; c < CH; c++) begin
                ok = 1;
                for (int j = SS; j < SS + DC; j++)
                    if (hist[j][c] == m_deb[c]) ok = 0;
                if (ok) begin
                    m_deb[c] = ~m_deb[c];
                    if (m_deb[c]) r[c] = 1'b1;
                    else f[c] = 1'b1;
                end
            end
        end
        if (started) sb_q.push_back({|(r | f), f, r, m_deb});
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_deb", 32'(debounced), 32'(e[1:0]));
            check("sb_rise", 32'(rise), 32'(e[3:2]));
            check("sb_fall", 32'(fall), 32'(e[5:4]));
            check("sb_any", 32'(any_change), 32'(e[6]));
        end
    end

    task automatic drive(input logic [1:0] v);
        @(negedge clock);
        raw_in = v;
    endtask

    task automatic wait_change(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clock);
            #2;
            if (any_change) begin
                n = i;
                break;
            end
        end
    endtask

    int n;

    initial begin
        // 1: reset values, no pulse on release, then both channels move
        repeat (3) @(negedge clock);
        check("rst_deb", 32'(debounced), 32'(2'b10));
        check("rst_rise", 32'(rise), 32'd0);
        check("rst_fall", 32'(fall), 32'd0);
        check("rst_any", 32'(any_change), 32'd0);
        reset = 1'b0;
        wait_change(40, n);
        check("rel_lat", 32'(n), 32'd6);
        check("rel_deb", 32'(debounced), 32'(2'b01));
        check("rel_rise", 32'(rise), 32'(2'b01));
        check("rel_fall", 32'(fall), 32'(2'b10));

        // 2: clean step on ch0
        drive(2'b00);
        wait_change(40, n);
        drive(2'b01);
        wait_change(40, n);
        check("step_lat", 32'(n), 32'd6);
        check("step_deb", 32'(debounced), 32'(2'b01));
        check("step_rise", 32'(rise), 32'(2'b01));
        @(posedge clock);
        #2;
        check("step_rise_end", 32'(rise), 32'd0);
        check("step_any_end", 32'(any_change), 32'd0);

        // 3: 3-cycle glitch on ch0 is rejected
        drive(2'b00);
        wait_change(40, n);
        drive(2'b01);
        repeat (2) @(negedge clock);
        drive(2'b00);
        wait_change(15, n);
        check("glitch_none", n, -1);
        check("glitch_deb", 32'(debounced), 32'(2'b00));

        // 4: bouncing ch1 falls 6 edges after the last transition
        drive(2'b10);
        wait_change(40, n);
        drive(2'b10);
        drive(2'b00);
        drive(2'b10);
        drive(2'b00);
        drive(2'b10);
        drive(2'b00);
        wait_change(40, n);
        check("bounce_lat", 32'(n), 32'd6);
        check("bounce_fall", 32'(fall), 32'(2'b10));
        check("bounce_deb", 32'(debounced), 32'(2'b00));

        // 5: simultaneous changes accepted on one edge
        drive(2'b10);
        wait_change(40, n);
        drive(2'b01);
        wait_change(40, n);
        check("sim_lat", 32'(n), 32'd6);
        check("sim_rise", 32'(rise), 32'(2'b01));
        check("sim_fall", 32'(fall), 32'(2'b10));
        check("sim_deb", 32'(debounced), 32'(2'b01));
        @(posedge clock);
        #2;
        check("sim_any_end", 32'(any_change), 32'd0);

        // 6: reset while ch0 count is 2 discards the count
        drive(2'b10);
        wait_change(40, n);
        drive(2'b11);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #2;
        check("mid_deb", 32'(debounced), 32'(2'b10));
        check("mid_any", 32'(any_change), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        wait_change(40, n);
        check("mid_lat", 32'(n), 32'd6);
        check("mid_rise", 32'(rise), 32'(2'b01));
        check("mid_deb2", 32'(debounced), 32'(2'b11));

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
